// File: rtl/log2_req_scheduler_if.sv
// Request/response bundle between client blocks and log2_req_scheduler.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. A requester holds req_valid and its
// req_a slice stable until it sees its own req_ready bit. The scheduler holds
// rsp_valid, rsp_id, rsp_o and rsp_err stable until rsp_ready is high.
// rsp_ready while rsp_valid is low has no effect.
interface log2_req_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int IN_W  = 5,
    parameter int OUT_W = 11
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*IN_W-1:0] req_a;
    logic [N_REQ-1:0]      req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [OUT_W-1:0]      rsp_o;
    logic                  rsp_err;

    // Client side: issues requests, consumes responses.
    modport master (
        output req_valid, req_a, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_o, rsp_err
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_o, rsp_err
    );
endinterface

// File: rtl/log2_req_scheduler.sv
// Round-robin scheduler sharing one fixed-latency iterative log2 core
// (unsigned IN_W operand, Q6.5 result) between N_REQ requesters.
// A zero operand is answered directly with an all-ones result and rsp_err.
// Optional feature macro: LOG2_REQ_SCHED_CACHE_EN adds a one-entry result
// cache so a repeated nonzero operand is answered without running the core.
module log2_req_scheduler #(
    parameter int N_REQ    = 4,
    parameter int IN_W     = 5,
    parameter int OUT_W    = 11,
    parameter int CORE_LAT = 35
) (
    input  logic                  clk,
    input  logic                  rst,        // asynchronous, active-low
    log2_req_scheduler_if.slave   bus,
    output logic                  core_start,
    output logic [IN_W-1:0]       core_a,
    input  logic [OUT_W-1:0]      core_o,
    output logic                  busy,
    output logic [1:0]            dbg_state
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(CORE_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [IN_W-1:0]  op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] rsp_o_q, rsp_o_d;
    logic             err_q, err_d;

`ifdef LOG2_REQ_SCHED_CACHE_EN
    logic             cache_vld_q, cache_vld_d;
    logic [IN_W-1:0]  cache_a_q, cache_a_d;
    logic [OUT_W-1:0] cache_o_q, cache_o_d;
`endif

    logic             gnt_found;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  cand;
    logic [IN_W-1:0]  gnt_a;
    logic [N_REQ-1:0] gnt_vec;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Decode the winner into its operand and a one-hot grant vector.
    always_comb begin
        gnt_a   = '0;
        gnt_vec = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == gnt_idx) begin
                gnt_a      = bus.req_a[k*IN_W +: IN_W];
                gnt_vec[k] = gnt_found;
            end
        end
    end

    // Next-state and datapath update for the IDLE/START/WAIT/RESP sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        rsp_o_d = rsp_o_q;
        err_d   = err_q;
`ifdef LOG2_REQ_SCHED_CACHE_EN
        cache_vld_d = cache_vld_q;
        cache_a_d   = cache_a_q;
        cache_o_d   = cache_o_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    id_d = gnt_idx;
                    op_d = gnt_a;
                    if (gnt_a == '0) begin
                        // log2(0) is undefined: answer at once, core untouched.
                        rsp_o_d = '1;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
`ifdef LOG2_REQ_SCHED_CACHE_EN
                    else if (cache_vld_q && (cache_a_q == gnt_a)) begin
                        rsp_o_d = cache_o_q;
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end
`endif
                    else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                cnt_d   = CNT_W'(CORE_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    // Only cycle in which core_o is trusted.
                    rsp_o_d = core_o;
                    err_d   = 1'b0;
                    state_d = S_RESP;
`ifdef LOG2_REQ_SCHED_CACHE_EN
                    cache_vld_d = 1'b1;
                    cache_a_d   = op_q;
                    cache_o_d   = core_o;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any job in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            rsp_o_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            rsp_o_q <= rsp_o_d;
            err_q   <= err_d;
        end
    end

`ifdef LOG2_REQ_SCHED_CACHE_EN
    // One-entry result cache, invalidated by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_vld_q <= 1'b0;
            cache_a_q   <= '0;
            cache_o_q   <= '0;
        end else begin
            cache_vld_q <= cache_vld_d;
            cache_a_q   <= cache_a_d;
            cache_o_q   <= cache_o_d;
        end
    end
`endif

    // req_ready is forced low during reset so no handshake can slip through.
    assign bus.req_ready = ((state_q == S_IDLE) && rst) ? gnt_vec : '0;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_o     = rsp_o_q;
    assign bus.rsp_err   = err_q;
    assign core_start    = (state_q == S_START);
    assign core_a        = op_q;
    assign busy          = (state_q != S_IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_log2_req_scheduler.sv
// Directed bench for log2_req_scheduler: vector table of single requests plus
// hand-written contention, backpressure, reset and cache sequences.
module tb_log2_req_scheduler;
    localparam int N_REQ    = 4;
    localparam int IN_W     = 5;
    localparam int OUT_W    = 11;
    localparam int CORE_LAT = 35;
    localparam int ID_W     = 2;
    localparam int LAT      = CORE_LAT + 2;
`ifdef LOG2_REQ_SCHED_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             core_start;
    logic [IN_W-1:0]  core_a;
    logic [OUT_W-1:0] core_o;
    logic             busy;
    logic [1:0]       dbg_state;

    log2_req_scheduler_if #(.N_REQ(N_REQ), .IN_W(IN_W), .OUT_W(OUT_W)) bus();

    log2_req_scheduler #(
        .N_REQ(N_REQ), .IN_W(IN_W), .OUT_W(OUT_W), .CORE_LAT(CORE_LAT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .core_start(core_start), .core_a(core_a), .core_o(core_o),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- core model ----------------
    function automatic logic [OUT_W-1:0] ref_log2(input logic [IN_W-1:0] a);
        real r;
        if (a == '0) return '1;
        r = $ln(real'(a)) / $ln(2.0) * 32.0 + 1.0e-9;
        return OUT_W'($rtoi(r));
    endfunction

    logic [IN_W-1:0] mdl_a = '0;
    int              mdl_cnt = 0;
    bit              mdl_run = 1'b0;

    always @(posedge clk) begin
        if (core_start) begin
            mdl_a   <= core_a;
            mdl_cnt <= CORE_LAT - 1;
            mdl_run <= 1'b1;
        end else if (mdl_run && mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
        end
    end
    // Garbage until the result is due, so early sampling shows up.
    assign core_o = (mdl_run && mdl_cnt == 0) ? ref_log2(mdl_a) : 11'h555;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [ID_W+OUT_W-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_accept(input int r, input string nm);
        int n = 0;
        #1;
        while (bus.req_ready[r] !== 1'b1 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk({nm, "_accept"}, {28'd0, bus.req_ready}, 32'(1 << r));
    endtask

    task automatic run_single(input int r, input logic [IN_W-1:0] a,
                              input logic [OUT_W-1:0] exp_o, input logic exp_err,
                              input int exp_lat, input int exp_starts, input string nm);
        int lat = 0;
        int starts = 0;
        int first_start = -1;
        bit busy_ok = 1'b1;
        bit rr_quiet = 1'b1;
        @(negedge clk);
        bus.req_valid = '0;
        bus.req_valid[r] = 1'b1;
        bus.req_a[r*IN_W +: IN_W] = a;
        bus.rsp_ready = 1'b1;
        wait_accept(r, nm);
        do begin
            @(negedge clk);
            bus.req_valid = '0;
            #1;
            lat++;
            if (core_start === 1'b1) begin
                starts++;
                if (first_start < 0) first_start = lat;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (bus.req_ready !== '0) rr_quiet = 1'b0;
        end while (bus.rsp_valid !== 1'b1 && lat < 200);
        chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_id"}, 32'(bus.rsp_id), 32'(r));
        chk({nm, "_o"}, 32'(bus.rsp_o), 32'(exp_o));
        chk({nm, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        chk({nm, "_starts"}, 32'(starts), 32'(exp_starts));
        if (exp_starts > 0) chk({nm, "_start_cyc"}, 32'(first_start), 32'd1);
        chk({nm, "_busy"}, 32'(busy_ok), 32'd1);
        chk({nm, "_rr_quiet"}, 32'(rr_quiet), 32'd1);
        @(negedge clk); #1;
        chk({nm, "_drop"}, {30'd0, bus.rsp_valid, busy}, 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int               req;
        logic [IN_W-1:0]  a;
        logic [OUT_W-1:0] exp_o;
        logic             exp_err;
    } vec_t;
    vec_t vecs[8];

    // ---------------- main test ----------------
    initial begin
        logic [N_REQ-1:0] taken;
        logic [ID_W+OUT_W-1:0] e;
        int exp_g[4];
        int gi;
        int n;
        bit ok;

        vecs[0] = '{req: 0, a: 5'd15, exp_o: 11'd125,  exp_err: 1'b0};
        vecs[1] = '{req: 1, a: 5'd31, exp_o: 11'd158,  exp_err: 1'b0};
        vecs[2] = '{req: 2, a: 5'd0,  exp_o: 11'h7FF,  exp_err: 1'b1};
        vecs[3] = '{req: 3, a: 5'd5,  exp_o: 11'd74,   exp_err: 1'b0};
        vecs[4] = '{req: 1, a: 5'd1,  exp_o: 11'd0,    exp_err: 1'b0};
        vecs[5] = '{req: 2, a: 5'd16, exp_o: 11'd128,  exp_err: 1'b0};
        vecs[6] = '{req: 0, a: 5'd3,  exp_o: 11'd50,   exp_err: 1'b0};
        vecs[7] = '{req: 3, a: 5'd0,  exp_o: 11'h7FF,  exp_err: 1'b1};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.rsp_ready = 1'b0;

        // Reset state, including req_ready held low with requests pending.
        repeat (3) @(negedge clk);
        bus.req_valid = 4'hF;
        #1;
        chk("rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
        chk("rst_outs", {6'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_o, bus.rsp_err,
                         core_start, core_a, busy}, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        bus.req_valid = '0;
        rst = 1'b1;

        // Single requests from the table.
        for (int i = 0; i < 8; i++) begin
            run_single(vecs[i].req, vecs[i].a, vecs[i].exp_o, vecs[i].exp_err,
                       vecs[i].exp_err ? 1 : LAT, vecs[i].exp_err ? 0 : 1,
                       $sformatf("vec%0d", i));
        end

        // Contention: all four valid, pointer at 0 -> grants 0,1,2,3.
        @(negedge clk);
        bus.req_a     = {5'd1, 5'd2, 5'd14, 5'd8};
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b1;
        exp_q.push_back({2'd0, 11'd96});
        exp_q.push_back({2'd1, 11'd121});
        exp_q.push_back({2'd2, 11'd32});
        exp_q.push_back({2'd3, 11'd0});
        exp_g = '{0, 1, 2, 3};
        gi = 0;
        for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
            #1;
            taken = '0;
            if (bus.req_ready !== '0) begin
                chk("cont_onehot", 32'($onehot(bus.req_ready)), 32'd1);
                for (int k = 0; k < N_REQ; k++) begin
                    if (bus.req_ready[k] === 1'b1 && gi < 4) begin
                        chk($sformatf("cont_gnt%0d", gi), 32'(k), 32'(exp_g[gi]));
                        gi++;
                    end
                end
                taken = bus.req_ready;
            end
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                e = exp_q.pop_front();
                chk("cont_id", 32'(bus.rsp_id), 32'(e[OUT_W +: ID_W]));
                chk("cont_o", 32'(bus.rsp_o), 32'(e[OUT_W-1:0]));
            end
            @(negedge clk);
            bus.req_valid = bus.req_valid & ~taken;
        end
        chk("cont_drain", 32'(exp_q.size()), 32'd0);
        chk("cont_ngnt", 32'(gi), 32'd4);

        // Backpressure: response held 10 cycles; req 1 waits meanwhile.
        @(negedge clk);
        bus.req_valid = 4'b0001;
        bus.req_a[0 +: IN_W] = 5'd14;
        bus.req_a[IN_W +: IN_W] = 5'd2;
        bus.rsp_ready = 1'b0;
        wait_accept(0, "bp");
        @(negedge clk);
        bus.req_valid = 4'b0010;
        #1;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk); #1; n++;
        end
        chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_o", 32'(bus.rsp_o), 32'd121);
        chk("bp_id", 32'(bus.rsp_id), 32'd0);
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_o !== 11'd121 || bus.rsp_id !== 2'd0 ||
                bus.rsp_err !== 1'b0 || bus.req_ready !== '0)
                ok = 1'b0;
        end
        chk("bp_stable", 32'(ok), 32'd1);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_xfer_rr", {28'd0, bus.req_ready}, 32'd0);
        @(negedge clk); #1;
        chk("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_next_grant", {28'd0, bus.req_ready}, 32'b0010);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk); #1; n++;
        end
        chk("bp_r1_id", 32'(bus.rsp_id), 32'd1);
        chk("bp_r1_o", 32'(bus.rsp_o), 32'd32);
        @(negedge clk);

        // Reset mid-WAIT: job abandoned, then a clean request.
        bus.req_valid = 4'b1000;
        bus.req_a[3*IN_W +: IN_W] = 5'd9;
        wait_accept(3, "rw");
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            bus.req_valid = '0;
        end
        #1;
        chk("rw_in_wait", 32'(dbg_state), 32'd2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rw_outs", {6'd0, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_o,
                        bus.rsp_err, core_start, busy}, 32'd0);
        chk("rw_core_a", 32'(core_a), 32'd0);
        chk("rw_state", 32'(dbg_state), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || core_start !== 1'b0) ok = 1'b0;
        end
        chk("rw_quiet", 32'(ok), 32'd1);
        run_single(1, 5'd4, 11'd64, 1'b0, LAT, 1, "rw_req1");

        // Back-to-back identical operands: second hits the cache when enabled.
        run_single(0, 5'd15, 11'd125, 1'b0, LAT, 1, "cache1");
        run_single(0, 5'd15, 11'd125, 1'b0, CACHE ? 1 : LAT, CACHE ? 0 : 1, "cache2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
